// File: rtl/eth_reg_responder.sv
// Device side of the CMD/RDN/WRN/SD register bus: address-phase decode, a 64x32
// byte-enabled register file with a read-only chip-ID halfword, and read/write answers.
module eth_reg_responder #(
    parameter logic [15:0] CHIP_ID     = 16'h8870,
    parameter logic [7:0]  CHIP_ID_OFF = 8'hC0
) (
    input  logic        clk40m,
    input  logic        reset,
    input  logic        CMD,
    input  logic        RDN,
    input  logic        WRN,
    inout  wire  [15:0] SD,
    input  logic [5:0]  bd_addr,
    output logic [31:0] bd_data,
    output logic        wr_done,
    output logic        rd_done,
    output logic        proto_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic [5:0] CHIP_IDX = CHIP_ID_OFF[7:2];

    state_t      st;
    logic [31:0] regs [64];
    logic        wrn_q, rdn_q;
    logic [3:0]  be;
    logic [5:0]  idx;

    logic        wr_rise, rd_fall, rd_rise, both_low, both_low_q;
    logic        hi, both_halves, be_bad, data_ev;
    logic        err_any, err_drop;
    logic [31:0] cur_word;
    logic [7:0]  lo_byte, hi_byte;
    logic        lo_en, hi_en;
    logic [15:0] rd_data;
    logic        sd_oe;

    assign state = st;

    // The chip-ID halfword is overlaid on every view of the array.
    always_comb begin
        bd_data = regs[bd_addr];
        if (bd_addr == CHIP_IDX) bd_data[15:0] = CHIP_ID;
        cur_word = regs[idx];
        if (idx == CHIP_IDX) cur_word[15:0] = CHIP_ID;
    end

    assign wr_rise    = ~wrn_q & WRN;
    assign rd_fall    = rdn_q & ~RDN;
    assign rd_rise    = ~rdn_q & RDN;
    assign both_low   = ~RDN & ~WRN;
    assign both_low_q = ~rdn_q & ~wrn_q;

    assign hi          = |be[3:2];
    assign both_halves = (|be[1:0]) & hi;
    assign be_bad      = (be == 4'b0000) | both_halves;
    assign data_ev     = (wr_rise | rd_fall) & ~CMD;

    assign err_drop = data_ev & (st == ADDR) & be_bad;
    assign err_any  = (data_ev & (st == IDLE)) | (both_low & ~both_low_q)
                    | (rd_fall & CMD) | err_drop;

    assign lo_byte = hi ? cur_word[23:16] : cur_word[7:0];
    assign hi_byte = hi ? cur_word[31:24] : cur_word[15:8];
    assign lo_en   = hi ? be[2] : be[0];
    assign hi_en   = hi ? be[3] : be[1];
    assign rd_data = both_halves ? 16'h0000
                   : {(hi_en ? hi_byte : 8'h00), (lo_en ? lo_byte : 8'h00)};

    // Combinational so the bus is valid the same cycle RDN is seen low; reset releases it at once.
    assign sd_oe = ~reset & ~RDN & WRN & ~CMD & ((st == RD) | (st == ADDR));
    assign SD    = sd_oe ? rd_data : 16'hzzzz;

    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            wrn_q     <= 1'b1;
            rdn_q     <= 1'b1;
            be        <= 4'b0000;
            idx       <= 6'd0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            proto_err <= 1'b0;
            for (int i = 0; i < 64; i++) regs[i] <= 32'h0;
        end else begin
            wrn_q     <= WRN;
            rdn_q     <= RDN;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            proto_err <= 1'b0;
            if (err_any) begin
                proto_err <= 1'b1;
                if (err_drop) st <= IDLE;
            end else if (wr_rise & CMD) begin
                be  <= SD[15:12];
                idx <= SD[7:2];
                st  <= ADDR;
            end else if ((st == ADDR) & wr_rise & ~CMD) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b] && !(idx == CHIP_IDX && b < 2))
                        regs[idx][b*8 +: 8] <= b[0] ? SD[15:8] : SD[7:0];
                end
                wr_done <= 1'b1;
                st      <= IDLE;
            end else if ((st == ADDR) & rd_fall & ~CMD) begin
                st <= RD;
            end else if ((st == RD) & rd_rise) begin
                rd_done <= 1'b1;
                st      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_eth_reg_responder.sv
// Directed bench for eth_reg_responder: emulates the register master's bus cycles
// and checks data, pulse counts, chip-ID protection, error handling and reset.
module tb_eth_reg_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd = 1'b0;
    logic        rdn = 1'b1;
    logic        wrn = 1'b1;
    logic [15:0] sd_drv = 16'h0;
    logic        sd_en = 1'b0;
    wire  [15:0] sd;
    logic [5:0]  bd_addr = 6'd0;
    logic [31:0] bd_data;
    logic        wr_done, rd_done, proto_err;
    logic [1:0]  st;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;

    assign sd = sd_en ? sd_drv : 16'hzzzz;

    eth_reg_responder dut (
        .clk40m   (clk),
        .reset    (reset),
        .CMD      (cmd),
        .RDN      (rdn),
        .WRN      (wrn),
        .SD       (sd),
        .bd_addr  (bd_addr),
        .bd_data  (bd_data),
        .wr_done  (wr_done),
        .rd_done  (rd_done),
        .proto_err(proto_err),
        .state    (st)
    );

    always #12 clk = ~clk;

    always @(posedge clk) begin
        if (wr_done)   wr_cnt  <= wr_cnt + 1;
        if (rd_done)   rd_cnt  <= rd_cnt + 1;
        if (proto_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic c, input logic [15:0] d);
        @(negedge clk);
        cmd = c; sd_drv = d; sd_en = 1'b1; wrn = 1'b0;
        @(negedge clk);
        wrn = 1'b1;
        @(negedge clk);
        sd_en = 1'b0; cmd = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(output logic [15:0] d);
        @(negedge clk);
        cmd = 1'b0; sd_en = 1'b0; rdn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d = sd;
        rdn = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input logic [5:0] a, output logic [31:0] d);
        bd_addr = a;
        #1;
        d = bd_data;
    endtask

    logic [15:0] rd;
    logic [31:0] word;
    int w0, r0, e0;
    logic [15:0] tbl [20];

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", {30'd0, st}, 32'd0);
        check("rst_oe", {31'd0, dut.sd_oe}, 32'd0);
        check("rst_pulses", {29'd0, wr_done, rd_done, proto_err}, 32'd0);
        peek(6'd48, word);
        check("rst_chipid", word, 32'h0000_8870);
        peek(6'd4, word);
        check("rst_reg4", word, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // word write / read
        w0 = wr_cnt; r0 = rd_cnt;
        bus_write(1'b1, 16'h3010);
        check("t1_state_addr", {30'd0, st}, 32'd1);
        bus_write(1'b0, 16'hBEEF);
        check("t1_wr_done", wr_cnt - w0, 1);
        peek(6'd4, word);
        check("t1_bd4", word, 32'h0000_BEEF);
        bus_write(1'b1, 16'h3010);
        bus_read(rd);
        check("t1_read", {16'd0, rd}, 32'h0000_BEEF);
        check("t1_rd_done", rd_cnt - r0, 1);
        check("t1_idle", {30'd0, st}, 32'd0);

        // byte lanes
        bus_write(1'b1, 16'h2015);
        bus_write(1'b0, 16'hA500);
        bus_write(1'b1, 16'h4016);
        bus_write(1'b0, 16'h005A);
        peek(6'd5, word);
        check("t2_bd5", word, 32'h005A_A500);
        bus_write(1'b1, 16'h8017);
        bus_read(rd);
        check("t2_byte3", {16'd0, rd}, 32'h0);
        bus_write(1'b1, 16'hC016);
        bus_read(rd);
        check("t2_hiword", {16'd0, rd}, 32'h0000_005A);

        // chip ID
        bus_write(1'b1, 16'h30C0);
        bus_read(rd);
        check("t3_chipid", {16'd0, rd}, 32'h0000_8870);
        bus_write(1'b1, 16'h30C0);
        bus_write(1'b0, 16'h1234);
        bus_write(1'b1, 16'h30C0);
        bus_read(rd);
        check("t3_chipid_ro", {16'd0, rd}, 32'h0000_8870);
        bus_write(1'b1, 16'hC0C2);
        bus_write(1'b0, 16'h4321);
        peek(6'd48, word);
        check("t3_upper", word, 32'h4321_8870);

        // protocol errors
        e0 = err_cnt; w0 = wr_cnt;
        bus_write(1'b0, 16'hDEAD);
        check("t4_noaddr_err", err_cnt - e0, 1);
        check("t4_noaddr_wr", wr_cnt - w0, 0);
        peek(6'd4, word);
        check("t4_noaddr_bd4", word, 32'h0000_BEEF);

        bus_write(1'b1, 16'h3010);
        e0 = err_cnt;
        @(negedge clk);
        rdn = 1'b0; wrn = 1'b0;
        @(negedge clk);
        check("t4_both_oe", {31'd0, dut.sd_oe}, 32'd0);
        check("t4_both_state", {30'd0, st}, 32'd1);
        cmd = 1'b1; sd_drv = 16'h3010; sd_en = 1'b1; rdn = 1'b1; wrn = 1'b1;
        @(negedge clk);
        sd_en = 1'b0; cmd = 1'b0;
        @(negedge clk);
        check("t4_both_err", err_cnt - e0, 1);

        e0 = err_cnt;
        cmd = 1'b1; rdn = 1'b0;
        @(negedge clk);
        check("t4_cmdrd_oe", {31'd0, dut.sd_oe}, 32'd0);
        rdn = 1'b1; cmd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_cmdrd_err", err_cnt - e0, 1);

        e0 = err_cnt;
        bus_write(1'b1, 16'h0010);
        bus_write(1'b0, 16'hFFFF);
        check("t4_be0_err", err_cnt - e0, 1);
        check("t4_be0_idle", {30'd0, st}, 32'd0);
        e0 = err_cnt;
        bus_write(1'b1, 16'h5010);
        bus_write(1'b0, 16'hFFFF);
        check("t4_split_err", err_cnt - e0, 1);
        peek(6'd4, word);
        check("t4_bd4_kept", word, 32'h0000_BEEF);

        // back-to-back: 20 writes then 20 read-backs
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            tbl[i] = 16'hA000 ^ (16'h0101 * 16'(i));
            bus_write(1'b1, 16'h3000 | 16'((8 + i) << 2));
            bus_write(1'b0, tbl[i]);
        end
        for (int i = 0; i < 20; i++) begin
            bus_write(1'b1, 16'h3000 | 16'((8 + i) << 2));
            bus_read(rd);
            check($sformatf("t5_rd%0d", i), {16'd0, rd}, {16'd0, tbl[i]});
        end
        check("t5_wr_cnt", wr_cnt - w0, 20);
        check("t5_rd_cnt", rd_cnt - r0, 20);
        check("t5_no_err", err_cnt - e0, 0);

        // reset during a read
        bus_write(1'b1, 16'h3020);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        check("t6_in_rd", {30'd0, st}, 32'd2);
        check("t6_driving", {31'd0, dut.sd_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_oe_off", {31'd0, dut.sd_oe}, 32'd0);
        check("t6_state", {30'd0, st}, 32'd0);
        peek(6'd8, word);
        check("t6_reg8", word, 32'h0);
        peek(6'd48, word);
        check("t6_chipid", word, 32'h0000_8870);
        @(negedge clk);
        rdn = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
